// File: rtl/inagu_ctrl_if.sv
// Job/step handshake bundle between the MVU input/weight AGU sequencer and its neighbours.
// master drives jobs and back-pressure; slave is the sequencer itself.
interface inagu_ctrl_if #(
    parameter int BCNT = 16
);
    logic            start;
    logic [BCNT-1:0] numsteps;
    logic            ready;
    logic            busy;
    logic            stall;
    logic            grp_end;
    logic            agu_clr;
    logic            agu_en;
    logic            rd_valid;
    logic            acc_done;
    logic            done;
    logic [31:0]     perf_stalls;

    modport master (
        output start, numsteps, stall, grp_end,
        input  ready, busy, agu_clr, agu_en, rd_valid, acc_done, done, perf_stalls
    );

    modport slave (
        input  start, numsteps, stall, grp_end,
        output ready, busy, agu_clr, agu_en, rd_valid, acc_done, done, perf_stalls
    );
endinterface

// File: rtl/inagu_ctrl.sv
// Input/weight AGU sequencer: clear, stepped run under back-pressure, read-latency-aligned strobes.
// Optional stall-cycle counter enabled by defining INAGU_CTRL_PERF_EN.
module inagu_ctrl #(
    parameter int BCNT  = 16,
    parameter int RDLAT = 2
) (
    input logic         clk,
    input logic         clr,
    inagu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    localparam int DW = (RDLAT > 1) ? $clog2(RDLAT) : 1;

    state_t          state, state_nxt;
    logic [BCNT-1:0] cnt;
    logic [DW-1:0]   dcnt;
    logic [RDLAT:1]  en_pipe;
    logic [RDLAT:1]  acc_pipe;
    logic            accept;

    assign accept = (state == IDLE) && bus.start;

    always_comb begin
        state_nxt   = state;
        bus.ready   = 1'b0;
        bus.busy    = 1'b1;
        bus.agu_clr = 1'b0;
        bus.agu_en  = 1'b0;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                bus.busy  = 1'b0;
                if (bus.start) state_nxt = CLEAR;
            end
            CLEAR: begin
                bus.agu_clr = 1'b1;
                state_nxt   = (cnt != '0) ? RUN : DRAIN;
            end
            RUN: begin
                bus.agu_en = ~bus.stall;
                if (!bus.stall && cnt == BCNT'(1)) state_nxt = DRAIN;
            end
            // Fixed RDLAT-cycle drain: after that many idle cycles the strobe
            // pipes are guaranteed empty, and a zero-length job gets the same timing.
            DRAIN: if (dcnt == DW'(RDLAT - 1)) state_nxt = DONE;
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            dcnt     <= '0;
            en_pipe  <= '0;
            acc_pipe <= '0;
        end else begin
            state <= state_nxt;
            if (accept)          cnt <= bus.numsteps;
            else if (bus.agu_en) cnt <= cnt - BCNT'(1);
            dcnt        <= (state == DRAIN) ? dcnt + DW'(1) : '0;
            en_pipe[1]  <= bus.agu_en;
            acc_pipe[1] <= bus.agu_en & bus.grp_end;
            for (int i = 2; i <= RDLAT; i++) begin
                en_pipe[i]  <= en_pipe[i-1];
                acc_pipe[i] <= acc_pipe[i-1];
            end
        end
    end

    assign bus.rd_valid = en_pipe[RDLAT];
    assign bus.acc_done = acc_pipe[RDLAT];

`ifdef INAGU_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (clr)
            perf_q <= '0;
        else if (accept)
            perf_q <= '0;
        else if (state == RUN && bus.stall && perf_q != '1)
            perf_q <= perf_q + 32'd1;
    end

    assign bus.perf_stalls = perf_q;
`else
    assign bus.perf_stalls = '0;
`endif
endmodule

// File: tb/tb_inagu_ctrl.sv
// Directed bench for inagu_ctrl: expected event cycles are queued when stimulus is driven
// and popped by a negedge monitor whenever the DUT raises the matching strobe.
module tb_inagu_ctrl;
    localparam int BCNT  = 16;
    localparam int RDLAT = 2;
`ifdef INAGU_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    inagu_ctrl_if #(.BCNT(BCNT)) bus ();

    inagu_ctrl #(.BCNT(BCNT), .RDLAT(RDLAT)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;
    bit mon_en = 1'b0;
    int q_clr[$], q_en[$], q_rdv[$], q_acc[$], q_done[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // every strobe must match the next queued cycle; a strobe with nothing queued compares against -1
    always @(negedge clk) begin : mon
        int e;
        if (mon_en) begin
            if (bus.agu_clr) begin
                e = (q_clr.size() > 0) ? q_clr.pop_front() : -1;
                chk("agu_clr_cycle", cyc, e);
            end
            if (bus.agu_en) begin
                e = (q_en.size() > 0) ? q_en.pop_front() : -1;
                chk("agu_en_cycle", cyc, e);
                chk("agu_en_under_stall", {31'd0, bus.stall}, 0);
            end
            if (bus.rd_valid) begin
                e = (q_rdv.size() > 0) ? q_rdv.pop_front() : -1;
                chk("rd_valid_cycle", cyc, e);
            end
            if (bus.acc_done) begin
                e = (q_acc.size() > 0) ? q_acc.pop_front() : -1;
                chk("acc_done_cycle", cyc, e);
            end
            if (bus.done) begin
                e = (q_done.size() > 0) ? q_done.pop_front() : -1;
                chk("done_cycle", cyc, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start in cycle T; per RUN cycle r: stall=stl[r], grp_end=grp[r]; xstart pulses start mid-run
    task automatic job(input int n, input logic [31:0] stl, input logic [31:0] grp, input bit xstart);
        int t, l, r, st, dn;
        t = cyc;
        bus.start    = 1'b1;
        bus.numsteps = n[BCNT-1:0];
        q_clr.push_back(t + 1);
        tick();
        bus.start = 1'b0;
        tick();
        l  = t + 1;
        r  = 0;
        st = 0;
        while (st < n) begin
            bus.stall   = stl[r];
            bus.grp_end = grp[r];
            bus.start   = xstart && (r % 2 == 0);
            if (xstart) bus.numsteps = 16'd9;
            if (!stl[r]) begin
                q_en.push_back(cyc);
                q_rdv.push_back(cyc + RDLAT);
                if (grp[r]) q_acc.push_back(cyc + RDLAT);
                l = cyc;
                st++;
            end
            r++;
            tick();
        end
        bus.stall   = 1'b0;
        bus.grp_end = 1'b0;
        bus.start   = 1'b0;
        dn = l + RDLAT + 1;
        q_done.push_back(dn);
        chk("busy_in_drain", {31'd0, bus.busy}, 1);
        repeat (dn - cyc) tick();
        chk("ready_in_done", {31'd0, bus.ready}, 0);
        tick();
        chk("ready_after_done", {31'd0, bus.ready}, 1);
        chk("busy_after_done", {31'd0, bus.busy}, 0);
        chk("events_outstanding", q_clr.size() + q_en.size() + q_rdv.size() + q_acc.size() + q_done.size(), 0);
        chk("perf_stalls", bus.perf_stalls, PERF ? (r - st) : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        clr          = 1'b1;
        bus.start    = 1'b0;
        bus.numsteps = '0;
        bus.stall    = 1'b0;
        bus.grp_end  = 1'b0;
        repeat (3) tick();
        chk("rst_ready", {31'd0, bus.ready}, 1);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_agu_clr", {31'd0, bus.agu_clr}, 0);
        chk("rst_agu_en", {31'd0, bus.agu_en}, 0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 0);
        chk("rst_acc_done", {31'd0, bus.acc_done}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_perf", bus.perf_stalls, 0);
        clr    = 1'b0;
        mon_en = 1'b1;
        tick();

        job(5, 32'b0, 32'b0, 1'b0);                    // basic: done at T+9
        job(4, 32'b0110, 32'b0, 1'b0);                 // stalls on RUN cycles 2 and 3
        job(6, 32'b0000010, 32'b1001010, 1'b0);        // grp on steps 3,6 and on the stalled cycle
        job(3, 32'b100, 32'b0, 1'b0);                  // stall while cnt==1 holds RUN
        job(0, 32'b0, 32'b0, 1'b0);                    // zero-length
        job(5, 32'b0, 32'b0, 1'b1);                    // start pulses with numsteps=9 while busy
        tick();

        // reset in the 3rd RUN cycle
        t = cyc;
        bus.start    = 1'b1;
        bus.numsteps = 16'd5;
        q_clr.push_back(t + 1);
        tick();
        bus.start = 1'b0;
        tick();
        q_en.push_back(cyc);
        q_rdv.push_back(cyc + RDLAT);
        tick();
        q_en.push_back(cyc);
        bus.grp_end = 1'b1;
        tick();
        bus.grp_end = 1'b0;
        q_en.push_back(cyc);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("midrst_ready", {31'd0, bus.ready}, 1);
        chk("midrst_busy", {31'd0, bus.busy}, 0);
        chk("midrst_rd_valid", {31'd0, bus.rd_valid}, 0);
        chk("midrst_acc_done", {31'd0, bus.acc_done}, 0);
        repeat (6) tick();
        chk("midrst_outstanding", q_clr.size() + q_en.size() + q_rdv.size() + q_acc.size() + q_done.size(), 0);

        job(5, 32'b0, 32'b0, 1'b0);                    // fresh job after abort
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
